// File: rtl/pipe_shifter.sv
// pipe_shifter: pipelined logarithmic barrel shifter with a valid/ready
// handshake on both sides.
//
// Stage k (k = 0..L-1) shifts by 2^k when bit k of the shift amount is set,
// so a result appears L cycles after acceptance. All stages advance
// together. While the last stage holds a result that downstream is not
// taking, the whole pipe freezes and in_ready drops.
//
// Ports
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   operation offered on in_*
//   in_ready   pipe accepts the offered operation this cycle
//   in_x       operand (N bits)
//   in_s       shift amount; only the low log2(N) bits are used
//   in_op      00 SLL, 01 SRL, 10 SRA, 11 ROL
//   in_tag     user tag returned with the result
//   out_valid  result presented on out_*
//   out_ready  downstream consumes the result this cycle
//   out_z      result
//   out_tag    tag of the operation that produced out_z
//   out_zero   registered "out_z is all zeros" flag
module pipe_shifter #(
  parameter int N    = 32,
  parameter int TAGW = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N-1:0]    in_x,
  input  logic [31:0]     in_s,
  input  logic [1:0]      in_op,
  input  logic [TAGW-1:0] in_tag,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [N-1:0]    out_z,
  output logic [TAGW-1:0] out_tag,
  output logic            out_zero
);

  localparam int L = $clog2(N);

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_ROL = 2'b11;

  logic            valid_q [L];
  logic [N-1:0]    data_q  [L];
  logic [1:0]      op_q    [L];
  logic [L-1:0]    amt_q   [L];
  logic [TAGW-1:0] tag_q   [L];
  logic            zero_q;

  logic            valid_d [L];
  logic [N-1:0]    data_d  [L];
  logic [1:0]      op_d    [L];
  logic [L-1:0]    amt_d   [L];
  logic [TAGW-1:0] tag_d   [L];
  logic            zero_d;

  logic advance;

  // One stage of the log shifter. SRA fills with the current MSB: every
  // earlier stage also filled with it, so it is still the operand's
  // original sign bit.
  function automatic logic [N-1:0] shift_stage(
    input logic [N-1:0] x,
    input logic [1:0]   op,
    input logic         en,
    input int           k
  );
    int sh;
    logic [N-1:0] r;
    sh = 1 << k;
    r  = x;
    if (en) begin
      case (op)
        OP_SLL:  r = x << sh;
        OP_SRL:  r = x >> sh;
        OP_SRA:  r = $signed(x) >>> sh;
        OP_ROL:  r = (x << sh) | (x >> (N - sh));
        default: r = x;
      endcase
    end
    return r;
  endfunction

  assign out_valid = valid_q[L-1];
  assign advance   = !out_valid || out_ready;
  assign in_ready  = advance;

  assign out_z    = data_q[L-1];
  assign out_tag  = tag_q[L-1];
  assign out_zero = zero_q;

  always_comb begin
    for (int k = 0; k < L; k++) begin
      valid_d[k] = 1'b0;
      data_d[k]  = '0;
      op_d[k]    = '0;
      amt_d[k]   = '0;
      tag_d[k]   = '0;
    end

    valid_d[0] = in_valid;
    op_d[0]    = in_op;
    amt_d[0]   = in_s[L-1:0];
    tag_d[0]   = in_tag;
    data_d[0]  = shift_stage(in_x, in_op, in_s[0], 0);

    for (int k = 1; k < L; k++) begin
      valid_d[k] = valid_q[k-1];
      op_d[k]    = op_q[k-1];
      amt_d[k]   = amt_q[k-1];
      tag_d[k]   = tag_q[k-1];
      data_d[k]  = shift_stage(data_q[k-1], op_q[k-1], amt_q[k-1][k], k);
    end

    zero_d = (data_d[L-1] == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < L; k++) begin
        valid_q[k] <= 1'b0;
        data_q[k]  <= '0;
        op_q[k]    <= '0;
        amt_q[k]   <= '0;
        tag_q[k]   <= '0;
      end
      zero_q <= 1'b0;
    end else if (advance) begin
      for (int k = 0; k < L; k++) begin
        valid_q[k] <= valid_d[k];
        data_q[k]  <= data_d[k];
        op_q[k]    <= op_d[k];
        amt_q[k]   <= amt_d[k];
        tag_q[k]   <= tag_d[k];
      end
      zero_q <= zero_d;
    end
  end

  // Upper amount bits and the last stage's op/amount have no consumer.
  logic unused_bits;
  assign unused_bits = ^{in_s, op_q[L-1], amt_q[L-1]};

endmodule

// File: tb/tb_pipe_shifter.sv
module tb_pipe_shifter;

  localparam int N    = 32;
  localparam int TAGW = 4;

  logic            clk;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [N-1:0]    in_x;
  logic [31:0]     in_s;
  logic [1:0]      in_op;
  logic [TAGW-1:0] in_tag;
  logic            out_valid;
  logic            out_ready;
  logic [N-1:0]    out_z;
  logic [TAGW-1:0] out_tag;
  logic            out_zero;

  int total;
  int bad;

  pipe_shifter #(.N(N), .TAGW(TAGW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .in_s      (in_s),
    .in_op     (in_op),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_z     (out_z),
    .out_tag   (out_tag),
    .out_zero  (out_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Offer one operation on an idle pipe and wait for its result.
  // lat counts rising edges, the accepting edge being 1.
  task automatic run_op(input logic [31:0] x, input logic [31:0] s,
                        input logic [1:0] op, input logic [3:0] tag,
                        output logic [31:0] z, output logic [3:0] t,
                        output logic zr, output int lat);
    @(negedge clk);
    in_valid  = 1'b1;
    in_x      = x;
    in_s      = s;
    in_op     = op;
    in_tag    = tag;
    out_ready = 1'b1;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    in_valid = 1'b0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    z  = out_z;
    t  = out_tag;
    zr = out_zero;
  endtask

  task automatic test_reset();
    #3;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    total++; if (out_z !== 32'h0) begin bad++; $display("FAIL reset_out_z got=%h want=0", out_z); end
    total++; if (out_tag !== 4'h0) begin bad++; $display("FAIL reset_out_tag got=%h want=0", out_tag); end
    total++; if (out_zero !== 1'b0) begin bad++; $display("FAIL reset_out_zero got=%b want=0", out_zero); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
  endtask

  task automatic test_sll_latency();
    logic [31:0] z; logic [3:0] t; logic zr; int lat;
    run_op(32'h0000_0001, 32'd31, 2'b00, 4'd3, z, t, zr, lat);
    total++; if (lat !== 5) begin bad++; $display("FAIL sll31_latency got=%0d want=5", lat); end
    total++; if (z !== 32'h8000_0000) begin bad++; $display("FAIL sll31_z got=%h want=80000000", z); end
    total++; if (t !== 4'd3) begin bad++; $display("FAIL sll31_tag got=%0d want=3", t); end
  endtask

  task automatic test_right_shifts();
    logic [31:0] z; logic [3:0] t; logic zr; int lat;
    run_op(32'h8000_0000, 32'd4, 2'b10, 4'd5, z, t, zr, lat);
    total++; if (z !== 32'hF800_0000) begin bad++; $display("FAIL sra4_z got=%h want=f8000000", z); end
    run_op(32'h8000_0000, 32'd4, 2'b01, 4'd6, z, t, zr, lat);
    total++; if (z !== 32'h0800_0000) begin bad++; $display("FAIL srl4_z got=%h want=08000000", z); end
    total++; if (t !== 4'd6) begin bad++; $display("FAIL srl4_tag got=%0d want=6", t); end
  endtask

  task automatic test_rol_wrap_zero_amount();
    logic [31:0] z; logic [3:0] t; logic zr; int lat;
    run_op(32'h8000_0001, 32'd1, 2'b11, 4'd7, z, t, zr, lat);
    total++; if (z !== 32'h0000_0003) begin bad++; $display("FAIL rol1_z got=%h want=00000003", z); end
    run_op(32'h0000_0001, 32'd33, 2'b00, 4'd8, z, t, zr, lat);
    total++; if (z !== 32'h0000_0002) begin bad++; $display("FAIL sll33_z got=%h want=00000002", z); end
    run_op(32'h8000_1234, 32'd0, 2'b10, 4'd9, z, t, zr, lat);
    total++; if (z !== 32'h8000_1234) begin bad++; $display("FAIL sra0_z got=%h want=80001234", z); end
    run_op(32'hDEAD_BEEF, 32'd32, 2'b11, 4'd10, z, t, zr, lat);
    total++; if (z !== 32'hDEAD_BEEF) begin bad++; $display("FAIL rol32_z got=%h want=deadbeef", z); end
    run_op(32'h1234_5678, 32'd8, 2'b11, 4'd11, z, t, zr, lat);
    total++; if (z !== 32'h3456_7812) begin bad++; $display("FAIL rol8_z got=%h want=34567812", z); end
  endtask

  task automatic test_zero_flag();
    logic [31:0] z; logic [3:0] t; logic zr; int lat;
    run_op(32'h0000_FFFF, 32'd16, 2'b00, 4'd1, z, t, zr, lat);
    total++; if (z !== 32'hFFFF_0000) begin bad++; $display("FAIL sll16_z got=%h want=ffff0000", z); end
    total++; if (zr !== 1'b0) begin bad++; $display("FAIL sll16_zero got=%b want=0", zr); end
    run_op(32'h8000_0000, 32'd1, 2'b00, 4'd2, z, t, zr, lat);
    total++; if (z !== 32'h0) begin bad++; $display("FAIL sll1_out_z got=%h want=00000000", z); end
    total++; if (zr !== 1'b1) begin bad++; $display("FAIL sll1_zero got=%b want=1", zr); end
  endtask

  // Tags 0,1,2 back-to-back, one idle cycle, then 3,4; out_ready is low
  // for cycles 5..7 while tag 0 sits at the output and tag 4 is offered.
  task automatic test_back_to_back();
    logic [31:0] bx   [5];
    logic [31:0] bexp [5];
    int sent, rcv;
    logic prev_stall;
    logic [31:0] held_z;
    logic [3:0]  held_t;
    logic accepted;
    bx   = '{32'h10, 32'h11, 32'h12, 32'h13, 32'h14};
    bexp = '{32'h10, 32'h22, 32'h48, 32'h98, 32'h140};
    sent = 0; rcv = 0; prev_stall = 1'b0; held_z = '0; held_t = '0;
    for (int c = 0; c < 40 && rcv < 5; c++) begin
      @(negedge clk);
      if (prev_stall) begin
        total++;
        if (out_valid !== 1'b1 || out_z !== held_z || out_tag !== held_t) begin
          bad++;
          $display("FAIL b2b_stall_stable cycle=%0d got=%b/%h/%0d want=1/%h/%0d",
                   c, out_valid, out_z, out_tag, held_z, held_t);
        end
      end
      out_ready = !(c >= 5 && c <= 7);
      if (sent < 5 && c != 3) begin
        in_valid = 1'b1;
        in_x     = bx[sent];
        in_s     = sent;
        in_op    = 2'b00;
        in_tag   = sent[3:0];
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (c >= 5 && c <= 7) begin
        total++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
          bad++;
          $display("FAIL b2b_stall_ready cycle=%0d got in_ready=%b out_valid=%b want 0/1", c, in_ready, out_valid);
        end
      end
      accepted = in_valid && in_ready;
      if (out_valid && out_ready) begin
        total++;
        if (out_z !== bexp[rcv] || out_tag !== rcv[3:0]) begin
          bad++;
          $display("FAIL b2b_result idx=%0d got=%h/%0d want=%h/%0d", rcv, out_z, out_tag, bexp[rcv], rcv);
        end
        rcv++;
      end
      prev_stall = out_valid && !out_ready;
      held_z     = out_z;
      held_t     = out_tag;
      if (accepted) sent++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    total++; if (rcv !== 5) begin bad++; $display("FAIL b2b_count got=%0d want=5", rcv); end
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      total++;
      if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_extra cycle=%0d got out_valid=%b tag=%0d want=0", c, out_valid, out_tag); end
    end
  endtask

  task automatic test_reset_midflight();
    logic [31:0] z; logic [3:0] t; logic zr; int lat;
    int waited;
    logic stale;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_x      = 32'hFFFF_0000 + i;
      in_s      = 32'd1;
      in_op     = 2'b01;
      in_tag    = 4'(12 + i);
    end
    @(negedge clk);
    in_valid = 1'b0;
    waited = 0;
    while (!out_valid && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL midrst_prefill got=%b want=1", out_valid); end
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL midrst_out_valid got=%b want=0", out_valid); end
    total++; if (out_z !== 32'h0) begin bad++; $display("FAIL midrst_out_z got=%h want=0", out_z); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL midrst_in_ready got=%b want=1", in_ready); end
    @(negedge clk);
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    stale = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) stale = 1'b1;
    end
    total++; if (stale !== 1'b0) begin bad++; $display("FAIL midrst_stale got=%b want=0", stale); end
    run_op(32'h0000_00F0, 32'd4, 2'b01, 4'd9, z, t, zr, lat);
    total++; if (lat !== 5) begin bad++; $display("FAIL midrst_new_latency got=%0d want=5", lat); end
    total++; if (z !== 32'h0000_000F) begin bad++; $display("FAIL midrst_new_z got=%h want=0000000f", z); end
    total++; if (t !== 4'd9) begin bad++; $display("FAIL midrst_new_tag got=%0d want=9", t); end
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_x      = '0;
    in_s      = '0;
    in_op     = '0;
    in_tag    = '0;
    out_ready = 1'b1;
    test_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    test_sll_latency();
    test_right_shifts();
    test_rol_wrap_zero_amount();
    test_zero_flag();
    test_back_to_back();
    test_reset_midflight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
